// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds up to DEPTH dispatched instructions,
// snoops the CDB for pending operands and issues one operand-complete entry
// per cycle to a single functional unit. Slot i owns result tag TAG_BASE+i.
// Optional feature macro RS_OLDEST_FIRST_EN: oldest-ready selection via
// per-slot age registers; when undefined the lowest-index ready slot issues.
module reservation_station #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [5:0]  TAG_BASE = 6'd1,
  parameter int unsigned OP_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            dispatch_valid,
  output logic            dispatch_ready,
  input  logic [OP_W-1:0] dispatch_op,
  input  logic            dispatch_rs1_busy,
  input  logic            dispatch_rs2_busy,
  input  logic [5:0]      dispatch_rs1_tag,
  input  logic [5:0]      dispatch_rs2_tag,
  input  logic [31:0]     dispatch_rs1_data,
  input  logic [31:0]     dispatch_rs2_data,
  output logic [5:0]      dispatch_tag,
  input  logic            cdb_valid,
  input  logic [5:0]      cdb_tag,
  input  logic [31:0]     cdb_data,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [OP_W-1:0] issue_op,
  output logic [31:0]     issue_rs1_data,
  output logic [31:0]     issue_rs2_data,
  output logic [5:0]      issue_tag,
  output logic [3:0]      occupancy
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] rs1_busy;
  logic [DEPTH-1:0] rs2_busy;
  logic [OP_W-1:0]  op       [DEPTH];
  logic [5:0]       rs1_tag  [DEPTH];
  logic [5:0]       rs2_tag  [DEPTH];
  logic [31:0]      rs1_data [DEPTH];
  logic [31:0]      rs2_data [DEPTH];
`ifdef RS_OLDEST_FIRST_EN
  logic [IW-1:0]    age      [DEPTH];
  logic [IW-1:0]    best_age;
  logic [IW-1:0]    new_age;
`endif

  logic [DEPTH-1:0] ready;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             issue_fire;
  logic             dispatch_fire;
  logic             rs1_bypass;
  logic             rs2_bypass;

  // Lowest-index free slot and valid-entry count, from registered state only
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    occupancy  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + 4'(valid[i]);
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign dispatch_ready = free_found;
  assign dispatch_tag   = TAG_BASE + 6'(free_idx);

  // Pick the entry to issue among operand-complete slots
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age  = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = valid[i] && !rs1_busy[i] && !rs2_busy[i];
`ifdef RS_OLDEST_FIRST_EN
      if (ready[i] && (!sel_found || age[i] < best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        best_age  = age[i];
      end
`else
      if (ready[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
`endif
    end
  end

  assign issue_valid    = sel_found;
  assign issue_op       = sel_found ? op[sel_idx]       : '0;
  assign issue_rs1_data = sel_found ? rs1_data[sel_idx] : '0;
  assign issue_rs2_data = sel_found ? rs2_data[sel_idx] : '0;
  assign issue_tag      = sel_found ? TAG_BASE + 6'(sel_idx) : '0;

  assign issue_fire    = issue_valid && issue_ready;
  assign dispatch_fire = dispatch_valid && dispatch_ready;
  assign rs1_bypass    = dispatch_rs1_busy && cdb_valid && (cdb_tag == dispatch_rs1_tag);
  assign rs2_bypass    = dispatch_rs2_busy && cdb_valid && (cdb_tag == dispatch_rs2_tag);
`ifdef RS_OLDEST_FIRST_EN
  // A new entry is younger than every entry surviving this cycle's issue
  assign new_age = IW'(occupancy - 4'(issue_fire));
`endif

  // Entry state update: CDB snoop, issue retirement, dispatch write
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= '0;
`ifdef RS_OLDEST_FIRST_EN
      for (int unsigned i = 0; i < DEPTH; i++) age[i] <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid[i] && cdb_valid && rs1_busy[i] && rs1_tag[i] == cdb_tag) begin
          rs1_busy[i] <= 1'b0;
          rs1_data[i] <= cdb_data;
        end
        if (valid[i] && cdb_valid && rs2_busy[i] && rs2_tag[i] == cdb_tag) begin
          rs2_busy[i] <= 1'b0;
          rs2_data[i] <= cdb_data;
        end
`ifdef RS_OLDEST_FIRST_EN
        if (issue_fire && valid[i] && IW'(i) != sel_idx && age[i] > age[sel_idx])
          age[i] <= age[i] - IW'(1);
`endif
      end
      if (issue_fire) valid[sel_idx] <= 1'b0;
      if (dispatch_fire) begin
        valid[free_idx]    <= 1'b1;
        op[free_idx]       <= dispatch_op;
        rs1_busy[free_idx] <= dispatch_rs1_busy && !rs1_bypass;
        rs2_busy[free_idx] <= dispatch_rs2_busy && !rs2_bypass;
        rs1_tag[free_idx]  <= dispatch_rs1_tag;
        rs2_tag[free_idx]  <= dispatch_rs2_tag;
        rs1_data[free_idx] <= rs1_bypass ? cdb_data : dispatch_rs1_data;
        rs2_data[free_idx] <= rs2_bypass ? cdb_data : dispatch_rs2_data;
`ifdef RS_OLDEST_FIRST_EN
        age[free_idx]      <= new_age;
`endif
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed vector table,
// a hand-written stall/full sequence, and randomized traffic against a
// queue-based reference model. Expectations follow RS_OLDEST_FIRST_EN.
module tb_reservation_station;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, dispatch_valid, dispatch_ready;
  logic [3:0]  dispatch_op;
  logic        dispatch_rs1_busy, dispatch_rs2_busy;
  logic [5:0]  dispatch_rs1_tag, dispatch_rs2_tag, dispatch_tag;
  logic [31:0] dispatch_rs1_data, dispatch_rs2_data;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_op;
  logic [31:0] issue_rs1_data, issue_rs2_data;
  logic [5:0]  issue_tag;
  logic [3:0]  occupancy;

  always #5 clk = ~clk;

  reservation_station #(.DEPTH(DEPTH), .TAG_BASE(6'd1), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op),
    .dispatch_rs1_busy(dispatch_rs1_busy), .dispatch_rs2_busy(dispatch_rs2_busy),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
    .dispatch_tag(dispatch_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_tag(issue_tag), .occupancy(occupancy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic dv, input logic [3:0] op,
                       input logic b1, input logic [5:0] t1, input logic [31:0] d1,
                       input logic b2, input logic [5:0] t2, input logic [31:0] d2,
                       input logic cv, input logic [5:0] ct, input logic [31:0] cd,
                       input logic ir);
    reset = rst; flush = fl; dispatch_valid = dv; dispatch_op = op;
    dispatch_rs1_busy = b1; dispatch_rs1_tag = t1; dispatch_rs1_data = d1;
    dispatch_rs2_busy = b2; dispatch_rs2_tag = t2; dispatch_rs2_data = d2;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd; issue_ready = ir;
  endtask

  task automatic check_outs(input string p, input logic e_dr, input logic e_chk, input logic [5:0] e_dtag,
                            input logic e_iv, input logic [3:0] e_op, input logic [31:0] e_d1,
                            input logic [31:0] e_d2, input logic [5:0] e_tag, input logic [3:0] e_occ);
    chk({p, " dispatch_ready"}, dispatch_ready, e_dr);
    if (e_chk) chk({p, " dispatch_tag"}, dispatch_tag, e_dtag);
    chk({p, " issue_valid"}, issue_valid, e_iv);
    chk({p, " issue_op"}, issue_op, e_op);
    chk({p, " issue_rs1_data"}, issue_rs1_data, e_d1);
    chk({p, " issue_rs2_data"}, issue_rs2_data, e_d2);
    chk({p, " issue_tag"}, issue_tag, e_tag);
    chk({p, " occupancy"}, occupancy, e_occ);
  endtask

  typedef struct {
    logic rst, fl, dv; logic [3:0] op;
    logic b1; logic [5:0] t1; logic [31:0] d1;
    logic b2; logic [5:0] t2; logic [31:0] d2;
    logic cv; logic [5:0] ct; logic [31:0] cd; logic ir;
    logic e_dr, e_chk; logic [5:0] e_dtag; logic e_iv; logic [3:0] e_op;
    logic [31:0] e_d1, e_d2; logic [5:0] e_tag; logic [3:0] e_occ;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic fl, input logic dv, input logic [3:0] op,
                              input logic b1, input logic [5:0] t1, input logic [31:0] d1,
                              input logic b2, input logic [5:0] t2, input logic [31:0] d2,
                              input logic cv, input logic [5:0] ct, input logic [31:0] cd, input logic ir,
                              input logic e_dr, input logic e_chk, input logic [5:0] e_dtag,
                              input logic e_iv, input logic [3:0] e_op, input logic [31:0] e_d1,
                              input logic [31:0] e_d2, input logic [5:0] e_tag, input logic [3:0] e_occ);
    vec_t v;
    v.rst = rst; v.fl = fl; v.dv = dv; v.op = op;
    v.b1 = b1; v.t1 = t1; v.d1 = d1; v.b2 = b2; v.t2 = t2; v.d2 = d2;
    v.cv = cv; v.ct = ct; v.cd = cd; v.ir = ir;
    v.e_dr = e_dr; v.e_chk = e_chk; v.e_dtag = e_dtag; v.e_iv = e_iv; v.e_op = e_op;
    v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_tag = e_tag; v.e_occ = e_occ;
    return v;
  endfunction

  // Reference model: slot contents plus a queue of slot indices in dispatch order
  logic        m_v  [DEPTH];
  logic [3:0]  m_op [DEPTH];
  logic        m_b1 [DEPTH], m_b2 [DEPTH];
  logic [5:0]  m_t1 [DEPTH], m_t2 [DEPTH];
  logic [31:0] m_d1 [DEPTH], m_d2 [DEPTH];
  int          m_order[$];

  function automatic logic m_rdy(input int i);
    return m_v[i] && !m_b1[i] && !m_b2[i];
  endfunction

  task automatic model_outputs(output logic dr, output logic [5:0] dtag, output logic iv,
                               output int sel, output logic [3:0] occ);
    dr = 1'b0; dtag = 6'd1; sel = -1; occ = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) begin dr = 1'b1; dtag = 6'(i + 1); end
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) occ = occ + 4'd1;
`ifdef RS_OLDEST_FIRST_EN
    foreach (m_order[k]) if (sel < 0 && m_rdy(m_order[k])) sel = m_order[k];
`else
    for (int i = 0; i < DEPTH; i++) if (sel < 0 && m_rdy(i)) sel = i;
`endif
    iv = (sel >= 0);
  endtask

  task automatic model_step();
    logic dr, iv; logic [5:0] dtag; int sel; logic [3:0] occ; int f;
    model_outputs(dr, dtag, iv, sel, occ);
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      m_order.delete();
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_v[i] && cdb_valid && m_b1[i] && m_t1[i] == cdb_tag) begin m_b1[i] = 1'b0; m_d1[i] = cdb_data; end
        if (m_v[i] && cdb_valid && m_b2[i] && m_t2[i] == cdb_tag) begin m_b2[i] = 1'b0; m_d2[i] = cdb_data; end
      end
      if (iv && issue_ready) begin
        m_v[sel] = 1'b0;
        for (int k = 0; k < m_order.size(); k++) if (m_order[k] == sel) begin m_order.delete(k); break; end
      end
      if (dispatch_valid && dr) begin
        f = int'(dtag) - 1;
        m_v[f] = 1'b1; m_op[f] = dispatch_op;
        m_t1[f] = dispatch_rs1_tag; m_t2[f] = dispatch_rs2_tag;
        if (dispatch_rs1_busy && cdb_valid && cdb_tag == dispatch_rs1_tag) begin m_b1[f] = 1'b0; m_d1[f] = cdb_data; end
        else begin m_b1[f] = dispatch_rs1_busy; m_d1[f] = dispatch_rs1_data; end
        if (dispatch_rs2_busy && cdb_valid && cdb_tag == dispatch_rs2_tag) begin m_b2[f] = 1'b0; m_d2[f] = cdb_data; end
        else begin m_b2[f] = dispatch_rs2_busy; m_d2[f] = dispatch_rs2_data; end
        m_order.push_back(f);
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    logic dr, iv; logic [5:0] dtag; int sel; logic [3:0] occ;

    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0; m_op[i] = '0; m_b1[i] = 1'b0; m_b2[i] = 1'b0;
      m_t1[i] = '0; m_t2[i] = '0; m_d1[i] = '0; m_d2[i] = '0;
    end

    //                rst fl dv op b1 t1 d1      b2 t2 d2       cv ct  cd      ir  dr chk dtag iv op d1      d2       tag occ
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       0,  1, 1, 1,  0, 0, 0,      0,       0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 0, 'h10,    0, 0, 'h20,    0, 0,  0,       0,  1, 1, 2,  1, 3, 'h10,   'h20,    1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       1,  1, 1, 1,  0, 0, 0,      0,       0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 5, 0,       0, 0, 2,       0, 0,  0,       0,  1, 1, 2,  0, 0, 0,      0,       0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       1,  1, 1, 2,  0, 0, 0,      0,       0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       0,  1, 1, 2,  0, 0, 0,      0,       0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 5,  'hAB,    0,  1, 1, 2,  1, 1, 'hAB,   2,       1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       1,  1, 1, 1,  0, 0, 0,      0,       0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 3,       1, 7, 0,       1, 7,  'h55,    0,  1, 1, 2,  1, 2, 3,      'h55,    1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       1,  1, 1, 1,  0, 0, 0,      0,       0, 0));
    tbl.push_back(mk(0, 0, 1, 9, 1, 9, 0,       0, 0, 'h900,   0, 0,  0,       0,  1, 1, 2,  0, 0, 0,      0,       0, 1));
    tbl.push_back(mk(0, 0, 1, 10,1, 9, 0,       0, 0, 'h901,   0, 0,  0,       0,  1, 1, 3,  0, 0, 0,      0,       0, 2));
    tbl.push_back(mk(0, 0, 1, 11,1, 9, 0,       0, 0, 'h902,   0, 0,  0,       0,  1, 1, 4,  0, 0, 0,      0,       0, 3));
    tbl.push_back(mk(0, 0, 1, 12,1, 9, 0,       0, 0, 'h903,   0, 0,  0,       0,  0, 0, 0,  0, 0, 0,      0,       0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 9,  'h99,    0,  0, 0, 0,  1, 9, 'h99,   'h900,   1, 4));
    tbl.push_back(mk(0, 0, 1, 15,0, 0, 'hEE,    0, 0, 'hEE,    0, 0,  0,       1,  1, 1, 1,  1, 10,'h99,   'h901,   2, 3));
    tbl.push_back(mk(0, 1, 1, 15,0, 0, 'hEE,    0, 0, 'hEE,    1, 9,  1,       1,  1, 1, 1,  0, 0, 0,      0,       0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 20,0,       0, 0, 'h500,   0, 0,  0,       0,  1, 1, 2,  0, 0, 0,      0,       0, 1));
    tbl.push_back(mk(0, 0, 1, 6, 1, 21,0,       0, 0, 'h600,   0, 0,  0,       0,  1, 1, 3,  0, 0, 0,      0,       0, 2));
    tbl.push_back(mk(0, 0, 1, 7, 1, 22,0,       0, 0, 'h700,   0, 0,  0,       0,  1, 1, 4,  0, 0, 0,      0,       0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 20, 'hA0,    0,  1, 1, 4,  1, 5, 'hA0,   'h500,   1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       1,  1, 1, 1,  0, 0, 0,      0,       0, 2));
    tbl.push_back(mk(0, 0, 1, 8, 1, 23,0,       0, 0, 'h800,   0, 0,  0,       0,  1, 1, 4,  0, 0, 0,      0,       0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 22, 'hA2,    0,  1, 1, 4,  1, 7, 'hA2,   'h700,   3, 3));
`ifdef RS_OLDEST_FIRST_EN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 23, 'hA3,    0,  1, 1, 4,  1, 7, 'hA2,   'h700,   3, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       1,  1, 1, 3,  1, 8, 'hA3,   'h800,   1, 2));
`else
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 23, 'hA3,    0,  1, 1, 4,  1, 8, 'hA3,   'h800,   1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       1,  1, 1, 1,  1, 7, 'hA2,   'h700,   3, 2));
`endif
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       1,  1, 1, 1,  0, 0, 0,      0,       0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,  0,       0,  1, 1, 1,  0, 0, 0,      0,       0, 0));

    foreach (tbl[r]) begin
      drive(tbl[r].rst, tbl[r].fl, tbl[r].dv, tbl[r].op, tbl[r].b1, tbl[r].t1, tbl[r].d1,
            tbl[r].b2, tbl[r].t2, tbl[r].d2, tbl[r].cv, tbl[r].ct, tbl[r].cd, tbl[r].ir);
      @(posedge clk); #1;
      check_outs($sformatf("row%0d", r), tbl[r].e_dr, tbl[r].e_chk, tbl[r].e_dtag, tbl[r].e_iv,
                 tbl[r].e_op, tbl[r].e_d1, tbl[r].e_d2, tbl[r].e_tag, tbl[r].e_occ);
    end

    // Full station: issue_ready must not reach dispatch_ready within the cycle,
    // and a stalled FU must see a stable selection
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 4'(k + 1), 0, 0, 32'(k), 0, 0, 32'(k + 'h40), 0, 0, 0, 0);
      @(posedge clk); #1;
    end
    check_outs("full", 0, 0, 0, 1, 1, 0, 'h40, 1, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("full comb dispatch_ready", dispatch_ready, 1'b0);
    @(posedge clk); #1;
    check_outs("freed", 1, 1, 1, 1, 2, 1, 'h41, 2, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_outs($sformatf("stall%0d", k), 1, 1, 1, 1, 2, 1, 'h41, 2, 3);
    end

    // Randomized traffic against the reference model; first cycle resets both
    for (int n = 0; n < 3000; n++) begin
      drive((n == 0) || ($urandom_range(0, 199) == 0), $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 6, 4'($urandom),
            $urandom_range(0, 1) == 1, 6'($urandom_range(1, 6)), $urandom,
            $urandom_range(0, 1) == 1, 6'($urandom_range(1, 6)), $urandom,
            $urandom_range(0, 1) == 1, 6'($urandom_range(1, 7)), $urandom,
            $urandom_range(0, 9) < 6);
      model_step();
      @(posedge clk); #1;
      model_outputs(dr, dtag, iv, sel, occ);
      if (iv)
        check_outs("rand", dr, dr, dtag, 1'b1, m_op[sel], m_d1[sel], m_d2[sel], 6'(sel + 1), occ);
      else
        check_outs("rand", dr, dr, dtag, 1'b0, '0, '0, '0, '0, occ);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
